rv32i_load_store_unit: RTL and testbench

Multi-cycle load/store unit directly downstream of the RV32I control unit in the non-pipelined core. Consumes the MemRead/MemWrite strobes, the ALU-computed effective address, the access size and rs2. Drives a simple req/ack data bus and stalls the core until the access completes. Returns sign- or zero-extended load data on the MemToReg write-back path and flags misaligned or faulted accesses to the trap logic.

---
 rtl/rv32i_load_store_unit.sv | 174 +++++++++++++++++
 tb/tb_rv32i_load_store_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_load_store_unit.sv
// Multi-cycle load/store unit for the non-pipelined RV32I core.
// Takes MemRead/MemWrite from the control unit and runs one access on a simple
// req/ack data bus. The core is stalled until the access completes. Load data is
// sign- or zero-extended for write-back. Misaligned accesses, bus errors,
// timeouts and illegal sizes are reported to the trap logic.
module rv32i_load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        fault_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, wdata_q, rdata_q, rdata_d;
  logic [1:0]    size_q;
  logic          uns_q, we_q;
  logic [3:0]    be_q;
  logic          mis_q, mis_d, flt_q, flt_d;
  logic          latch_en;

  logic          start, size_bad, addr_bad;
  logic [3:0]    be_new;
  logic [31:0]   wlane_new, lane, load_ext;

  // Classify the incoming request and form the byte enables and the replicated store lanes.
  always_comb begin
    start    = mem_read_i | mem_write_i;
    size_bad = (size_i == 2'b11);
    addr_bad = ((size_i == 2'b01) && addr_i[0]) ||
               ((size_i == 2'b10) && (addr_i[1:0] != 2'b00));
    case (size_i)
      2'b00: begin
        be_new    = 4'b0001 << addr_i[1:0];
        wlane_new = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << {addr_i[1], 1'b0};
        wlane_new = {2{wdata_i[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wlane_new = wdata_i;
      end
    endcase
  end

  // Pull the addressed lane out of the read word and extend it to 32 bits.
  always_comb begin
    lane = bus_rdata_i >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_ext = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  // Next-state, stall, and the result/flag values loaded on entry to RESP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    mis_d    = 1'b0;
    flt_d    = 1'b0;
    latch_en = 1'b0;
    stall_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          stall_o = 1'b1;
          if (size_bad) begin
            flt_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else if (addr_bad) begin
            mis_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            latch_en = 1'b1;
            cnt_d    = '0;
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (bus_err_i) begin
          flt_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else if (bus_ack_i) begin
          rdata_d = we_q ? '0 : load_ext;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          flt_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, timeout counter, result register and the latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      flt_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      flt_q   <= flt_d;
      if (latch_en) begin
        addr_q  <= addr_i;
        wdata_q <= wlane_new;
        size_q  <= size_i;
        uns_q   <= unsigned_i;
        we_q    <= ~mem_read_i;
        be_q    <= be_new;
      end
    end
  end

  // Bus signals are driven only while the request is outstanding.
  assign bus_req_o   = (state_q == REQ);
  assign bus_we_o    = bus_req_o & we_q;
  assign bus_addr_o  = bus_req_o ? {addr_q[31:2], 2'b00} : '0;
  assign bus_wdata_o = bus_req_o ? wdata_q : '0;
  assign bus_be_o    = bus_req_o ? be_q : '0;

  assign done_o     = (state_q == RESP);
  assign misalign_o = mis_q;
  assign fault_o    = flt_q;
  assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_rv32i_load_store_unit.sv
// Self-checking bench for rv32i_load_store_unit: directed accesses, a
// behavioural protocol model and a per-cycle comparison against it.
module tb_rv32i_load_store_unit;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read_i, mem_write_i, unsigned_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, done_o, misalign_o, fault_o;
  logic [31:0] rdata_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i, bus_err_i;
  logic [31:0] bus_rdata_i;

  int checks   = 0;
  int failures = 0;

  rv32i_load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .size_i(size_i), .unsigned_i(unsigned_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
    .misalign_o(misalign_o), .fault_o(fault_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 bus access outstanding, 2 reporting.
  int unsigned m_ph, m_cnt, m_off, m_nb;
  logic        m_we, m_uns, m_mis, m_flt;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  function automatic logic [31:0] extract(input logic [31:0] word, input int unsigned off,
                                          input int unsigned nb, input logic uns);
    logic [31:0] v;
    v = word >> (8 * off);
    if (nb == 4) return v;
    v = v % (32'd1 << (8 * nb));
    if (!uns && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_cnt = 0; m_rdata = '0; m_mis = 1'b0; m_flt = 1'b0;
    end else begin
      case (m_ph)
        0: if (mem_read_i || mem_write_i) begin
          m_mis = 1'b0; m_flt = 1'b0;
          m_we  = !mem_read_i;
          m_uns = unsigned_i;
          m_off = addr_i % 4;
          m_nb  = 1 << size_i;
          if (size_i == 2'b11) begin
            m_flt = 1'b1; m_rdata = '0; m_ph = 2;
          end else if ((addr_i % m_nb) != 0) begin
            m_mis = 1'b1; m_rdata = '0; m_ph = 2;
          end else begin
            m_addr = addr_i - m_off;
            m_be   = 4'(((1 << m_nb) - 1) << m_off);
            case (m_nb)
              1:       m_wdata = wdata_i[7:0] * 32'h0101_0101;
              2:       m_wdata = wdata_i[15:0] * 32'h0001_0001;
              default: m_wdata = wdata_i;
            endcase
            m_cnt = 1;
            m_ph  = 1;
          end
        end
        1: begin
          if (bus_err_i) begin
            m_flt = 1'b1; m_rdata = '0; m_ph = 2;
          end else if (bus_ack_i) begin
            m_rdata = m_we ? 32'h0 : extract(bus_rdata_i, m_off, m_nb, m_uns);
            m_ph = 2;
          end else if (m_cnt == T) begin
            m_flt = 1'b1; m_rdata = '0; m_ph = 2;
          end else begin
            m_cnt++;
          end
        end
        default: m_ph = 0;
      endcase
    end
  end

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("stall", stall_o, (m_ph == 1) || (m_ph == 0 && (mem_read_i || mem_write_i)));
      chk("bus_req", bus_req_o, m_ph == 1);
      chk("done", done_o, m_ph == 2);
      chk("misalign", misalign_o, (m_ph == 2) && m_mis);
      chk("fault", fault_o, (m_ph == 2) && m_flt);
      chk("rdata", rdata_o, m_rdata);
      chk("bus_be", bus_be_o, (m_ph == 1) ? m_be : 4'h0);
      if (m_ph == 1) begin
        chk("bus_we", bus_we_o, m_we);
        chk("bus_addr", bus_addr_o, m_addr);
        chk("bus_wdata", bus_wdata_o, m_wdata);
      end
    end
  end

  // Present a request for one cycle, then scramble the request inputs.
  task automatic start_acc(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd);
    mem_read_i = rd; mem_write_i = wr; size_i = sz; unsigned_i = uns;
    addr_i = a; wdata_i = wd;
    @(posedge clk); #1;
    mem_read_i = 1'b0; mem_write_i = 1'b0; size_i = 2'b11; unsigned_i = 1'b1;
    addr_i = 32'hFFFF_FFFF; wdata_i = 32'h5A5A_5A5A;
  endtask

  // Let the request wait, then terminate it in one cycle.
  task automatic finish_bus(input int waits, input logic ack, input logic err,
                            input logic [31:0] rd);
    repeat (waits) begin @(posedge clk); #1; end
    bus_ack_i = ack; bus_err_i = err; bus_rdata_i = rd;
    @(posedge clk); #1;
    bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = 32'h0BAD_F00D;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int reqc, guard;
    rst_n = 1'b0;
    mem_read_i = 1'b0; mem_write_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
    addr_i = '0; wdata_i = '0;
    bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_req", bus_req_o, 0);
    chk("rst_be", bus_be_o, 0);
    chk("rst_stall", stall_o, 0);
    rst_n = 1'b1;
    step();

    // LW 0x1000
    start_acc(1, 0, 2'b10, 0, 32'h0000_1000, 32'h0);
    chk("lw_addr", bus_addr_o, 32'h0000_1000);
    chk("lw_be", bus_be_o, 4'hF);
    chk("lw_stall1", stall_o, 1);
    finish_bus(0, 1, 0, 32'hDEAD_BEEF);
    chk("lw_done2", done_o, 1);
    chk("lw_stall2", stall_o, 0);
    chk("lw_rdata", rdata_o, 32'hDEAD_BEEF);
    step();
    chk("lw_pulse", done_o, 0);
    chk("lw_hold", rdata_o, 32'hDEAD_BEEF);

    // LB / LBU 0x1003
    start_acc(1, 0, 2'b00, 0, 32'h0000_1003, 32'h0);
    chk("lb_be", bus_be_o, 4'h8);
    finish_bus(0, 1, 0, 32'h8000_0000);
    chk("lb_rdata", rdata_o, 32'hFFFF_FF80);
    step();
    start_acc(1, 0, 2'b00, 1, 32'h0000_1003, 32'h0);
    finish_bus(0, 1, 0, 32'h8000_0000);
    chk("lbu_rdata", rdata_o, 32'h0000_0080);
    step();

    // LH 0x0002 signed
    start_acc(1, 0, 2'b01, 0, 32'h0000_0002, 32'h0);
    finish_bus(0, 1, 0, 32'h8001_0000);
    chk("lh_rdata", rdata_o, 32'hFFFF_8001);
    step();

    // SH 0x2002 with 5 wait cycles
    start_acc(0, 1, 2'b01, 0, 32'h0000_2002, 32'h1234_ABCD);
    for (int i = 0; i < 5; i++) begin
      chk("sh_we", bus_we_o, 1);
      chk("sh_be", bus_be_o, 4'hC);
      chk("sh_wdata", bus_wdata_o, 32'hABCD_ABCD);
      chk("sh_nodone", done_o, 0);
      step();
    end
    finish_bus(0, 1, 0, 32'hFFFF_FFFF);
    chk("sh_done", done_o, 1);
    chk("sh_rdata", rdata_o, 32'h0);
    step();

    // SB 0x0005
    start_acc(0, 1, 2'b00, 0, 32'h0000_0005, 32'h0000_00A5);
    chk("sb_be", bus_be_o, 4'h2);
    chk("sb_wdata", bus_wdata_o, 32'hA5A5_A5A5);
    finish_bus(1, 1, 0, 32'h0);
    step();

    // Misaligned LW and illegal size
    start_acc(1, 0, 2'b10, 0, 32'h0000_1001, 32'h0);
    chk("mis_req", bus_req_o, 0);
    chk("mis_flag", misalign_o, 1);
    chk("mis_done", done_o, 1);
    chk("mis_fault", fault_o, 0);
    step();
    start_acc(1, 0, 2'b11, 0, 32'h0000_1000, 32'h0);
    chk("ill_req", bus_req_o, 0);
    chk("ill_fault", fault_o, 1);
    chk("ill_done", done_o, 1);
    step();

    // Timeout
    start_acc(1, 0, 2'b10, 0, 32'h0000_3000, 32'h0);
    reqc = 0; guard = 0;
    while (!done_o && guard < 40) begin
      if (bus_req_o) reqc++;
      step();
      guard++;
    end
    chk("to_reached", done_o, 1);
    chk("to_req_cycles", reqc, T);
    chk("to_fault", fault_o, 1);
    chk("to_rdata", rdata_o, 0);
    step();

    // ack and err together
    start_acc(1, 0, 2'b10, 0, 32'h0000_0040, 32'h0);
    finish_bus(1, 1, 1, 32'h1234_5678);
    chk("err_fault", fault_o, 1);
    chk("err_rdata", rdata_o, 0);
    step();

    // Reset while the request is outstanding
    start_acc(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", bus_req_o, 0);
    chk("arst_done", done_o, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("arst_nodone", done_o, 0);
      step();
    end
    start_acc(1, 0, 2'b10, 0, 32'h0000_0040, 32'h0);
    finish_bus(0, 1, 0, 32'h1122_3344);
    chk("post_rst_rdata", rdata_o, 32'h1122_3344);
    step();

    // Both strobes: read wins
    start_acc(1, 1, 2'b10, 0, 32'h0000_0008, 32'hCAFE_BABE);
    chk("both_we", bus_we_o, 0);
    finish_bus(0, 1, 0, 32'h0000_00AA);
    chk("both_rdata", rdata_o, 32'h0000_00AA);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
